// File: rtl/pe_inst_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_inst_sequencer_pkg
// Brief    : Operand namespace indices, sequencer state encoding and the
//            operand-pop bit helper shared by the PE sequencer and PU arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package pe_inst_sequencer_pkg;

    localparam int NAMESPACE_NULL      = 0;
    localparam int NAMESPACE_IMMEDIATE = 1;
    localparam int NAMESPACE_INTERIM   = 2;
    localparam int NAMESPACE_MEMORY    = 3;
    localparam int NAMESPACE_NEIGHBOR  = 4;
    localparam int NAMESPACE_BUS       = 5;

    // Bit positions inside operand_pop = {gb_bus, pe_bus, pu_neigh, pe_neigh}
    localparam int POP_PE_NEIGH = 0;
    localparam int POP_PU_NEIGH = 1;
    localparam int POP_PE_BUS   = 2;
    localparam int POP_GB_BUS   = 3;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_FETCH = 2'd1,
        SEQ_ISSUE = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_e;

    function automatic logic [3:0] pop_select(input logic is_neigh,
                                              input logic is_bus,
                                              input logic index_lsb);
        logic [3:0] r;
        r               = '0;
        r[POP_PE_NEIGH] = is_neigh & ~index_lsb;
        r[POP_PU_NEIGH] = is_neigh &  index_lsb;
        r[POP_PE_BUS]   = is_bus   & ~index_lsb;
        r[POP_GB_BUS]   = is_bus   &  index_lsb;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_operand_pop.sv
`default_nettype none
// ============================================================================
// Module   : pe_operand_pop
// Brief    : Combinational map from the two source namespace decodes to the
//            neighbour/bus operand registers they consume.
// Revision : 1.0 - initial release
// ============================================================================
module pe_operand_pop
    import pe_inst_sequencer_pkg::*;
#(
    parameter int SRC_NUM = 3
) (
    input  logic [(1<<SRC_NUM)-1:0] src0_decoder_out,
    input  logic [(1<<SRC_NUM)-1:0] src1_decoder_out,
    input  logic                    src0_index_lsb,
    input  logic                    src1_index_lsb,
    output logic [3:0]              operand_pop
);

    // Only the neighbour and bus namespaces own poppable registers
    logic w_unused_dec;
    assign w_unused_dec = ^{src0_decoder_out, src1_decoder_out};

    // OR merge: a register named by both sources is consumed once
    assign operand_pop =
        pop_select(src0_decoder_out[NAMESPACE_NEIGHBOR],
                   src0_decoder_out[NAMESPACE_BUS], src0_index_lsb) |
        pop_select(src1_decoder_out[NAMESPACE_NEIGHBOR],
                   src1_decoder_out[NAMESPACE_BUS], src1_index_lsb);

endmodule
`default_nettype wire

// File: rtl/pe_inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pe_inst_sequencer
// Brief    : Per-PE instruction issue controller: steps instruction memory,
//            holds on operand stall, repeats the program, pulses done.
//            Optional stall/issue counters under PE_SEQ_STALL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pe_inst_sequencer
    import pe_inst_sequencer_pkg::*;
#(
    parameter int INST_ADDR_LEN = 8,
    parameter int ITER_LEN      = 16,
    parameter int SRC_NUM       = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [INST_ADDR_LEN-1:0] last_inst_addr,
    input  logic [ITER_LEN-1:0]      num_iter,
    output logic [INST_ADDR_LEN-1:0] inst_addr,
    output logic                     inst_rd_en,
    output logic                     inst_valid,
    input  logic                     inst_stall_comp,
    input  logic [(1<<SRC_NUM)-1:0]  src0_decoder_out,
    input  logic [(1<<SRC_NUM)-1:0]  src1_decoder_out,
    input  logic                     src0_index_lsb,
    input  logic                     src1_index_lsb,
    output logic                     inst_issue,
    output logic [3:0]               operand_pop,
    output logic                     busy,
`ifdef PE_SEQ_STALL_PERF_EN
    output logic [31:0]              stall_cycles,
    output logic [31:0]              issue_count,
`endif
    output logic                     done
);

    seq_state_e               state_q, state_d;
    logic [INST_ADDR_LEN-1:0] pc_q, pc_d;
    logic [INST_ADDR_LEN-1:0] last_q, last_d;
    logic [ITER_LEN-1:0]      iter_q, iter_d;
    logic [ITER_LEN-1:0]      niter_q, niter_d;
    logic [3:0]               w_pop;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= SEQ_IDLE;
            pc_q    <= '0;
            last_q  <= '0;
            iter_q  <= '0;
            niter_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            last_q  <= last_d;
            iter_q  <= iter_d;
            niter_q <= niter_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        last_d     = last_q;
        iter_d     = iter_q;
        niter_d    = niter_q;
        inst_addr  = '0;
        inst_rd_en = 1'b0;
        inst_valid = 1'b0;
        inst_issue = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    last_d  = last_inst_addr;
                    niter_d = (num_iter == '0) ? ITER_LEN'(1) : num_iter;
                    pc_d    = '0;
                    iter_d  = '0;
                    state_d = SEQ_FETCH;
                end
            end
            SEQ_FETCH: begin
                inst_rd_en = 1'b1;
                busy       = 1'b1;
                state_d    = SEQ_ISSUE;
            end
            SEQ_ISSUE: begin
                inst_rd_en = 1'b1;
                inst_valid = 1'b1;
                busy       = 1'b1;
                inst_addr  = pc_q;
                if (!inst_stall_comp) begin
                    inst_issue = 1'b1;
                    // Present pc+1 now so the next word is ready with no bubble
                    if (pc_q != last_q) begin
                        pc_d      = pc_q + INST_ADDR_LEN'(1);
                        inst_addr = pc_d;
                    end else if (iter_q != niter_q - ITER_LEN'(1)) begin
                        iter_d  = iter_q + ITER_LEN'(1);
                        pc_d    = '0;
                        state_d = SEQ_FETCH;
                    end else begin
                        state_d = SEQ_DONE;
                    end
                end
            end
            SEQ_DONE: begin
                done    = 1'b1;
                state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    pe_operand_pop #(
        .SRC_NUM (SRC_NUM)
    ) u_operand_pop (
        .src0_decoder_out (src0_decoder_out),
        .src1_decoder_out (src1_decoder_out),
        .src0_index_lsb   (src0_index_lsb),
        .src1_index_lsb   (src1_index_lsb),
        .operand_pop      (w_pop)
    );

    assign operand_pop = inst_issue ? w_pop : 4'b0000;

`ifdef PE_SEQ_STALL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] issue_cnt_q;
    logic        w_start_accept;
    logic        w_stall_cycle;

    assign w_start_accept = (state_q == SEQ_IDLE) && start;
    assign w_stall_cycle  = (state_q == SEQ_ISSUE) && inst_stall_comp;

    always_ff @(posedge clk) begin
        if (!rstn || w_start_accept) begin
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            if (w_stall_cycle && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (inst_issue && !(&issue_cnt_q))
                issue_cnt_q <= issue_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign issue_count  = issue_cnt_q;
`else
    // Counters and their ports are absent in this build
`endif

endmodule
`default_nettype wire
